fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the load-use hazard unit.
- Owns the PC and drives a synchronous instruction memory (1-cycle read latency).
- Presents the fetched instruction, its PC and its rs1/rs2 fields (IFrs1/IFrs2) to decode and to the hazard unit.
- Consumes the hazard unit's stall and execute's branch/jump redirect; inserts bubbles on redirect.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_hold_buf.sv | 43 ++++
 rtl/fetch_stage.sv | 71 +++++++
 tb/tb_fetch_stage.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants and fetch-stage types.
package riscv_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
  localparam int          RS1_MSB   = 19;
  localparam int          RS1_LSB   = 15;
  localparam int          RS2_MSB   = 24;
  localparam int          RS2_LSB   = 20;

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} fetch_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and IF/ID outputs.
interface fetch_stage_if;
  import riscv_pkg::*;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] IFinstr;
  logic [XLEN-1:0] IFpc;
  logic            IFvalid;
  logic [4:0]      IFrs1;
  logic [4:0]      IFrs2;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, IFinstr, IFpc, IFvalid, IFrs1, IFrs2
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, IFinstr, IFpc, IFvalid, IFrs1, IFrs2
  );
endinterface

// File: rtl/fetch_hold_buf.sv
// Holds the IF/ID instruction across a stall and selects what decode sees.
module fetch_hold_buf
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic            vld_d,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] instr
);
  fetch_state_e    state_q, state_n;
  logic [XLEN-1:0] hold_q, hold_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_n;
      hold_q  <= hold_n;
    end
  end

  // Capture only on the first stall cycle; memory output changes after that.
  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    if (redirect) begin
      state_n = RUN;
    end else if (stall) begin
      if (state_q == RUN) begin
        hold_n  = vld_d ? rdata : NOP_INSTR;
        state_n = HOLD;
      end
    end else begin
      state_n = RUN;
    end
  end

  assign instr = (state_q == HOLD) ? hold_q : (vld_d ? rdata : NOP_INSTR);
endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, sync imem port, stall hold, redirect bubbles.
// Optional FETCH_PERF_CNT_EN adds fetched/stall/flush cycle counters.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_stall,
  output logic [31:0]   perf_flush
`endif
);
  logic [XLEN-1:0] pc_f, pc_d;
  logic            vld_d;
  logic [XLEN-1:0] instr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f  <= RESET_PC;
      pc_d  <= RESET_PC;
      vld_d <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc_f  <= bus.redirect_pc & ~XLEN'(3);
      vld_d <= 1'b0;
    end else if (!bus.stall) begin
      pc_d  <= pc_f;
      pc_f  <= pc_f + XLEN'(4);
      vld_d <= 1'b1;
    end
  end

  fetch_hold_buf u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (bus.stall),
    .redirect (bus.redirect_valid),
    .vld_d    (vld_d),
    .rdata    (bus.imem_rdata),
    .instr    (instr)
  );

  assign bus.imem_addr = pc_f;
  assign bus.IFinstr   = instr;
  assign bus.IFpc      = pc_d;
  assign bus.IFvalid   = vld_d;
  // Bubbles report x0 so the hazard unit never stalls on them.
  assign bus.IFrs1     = vld_d ? instr[RS1_MSB:RS1_LSB] : 5'd0;
  assign bus.IFrs2     = vld_d ? instr[RS2_MSB:RS2_LSB] : 5'd0;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else if (bus.redirect_valid) begin
      perf_flush <= perf_flush + 32'd1;
    end else if (bus.stall) begin
      perf_stall <= perf_stall + 32'd1;
    end else if (vld_d) begin
      perf_fetched <= perf_fetched + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage; memory word at addr a is 0x100+a/4 except 0x200.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst_n, rst2_n;
  always #5 clk = ~clk;

  fetch_stage_if bus ();
  fetch_stage_if bus2 ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf, ps, pfl, pf2, ps2, pfl2;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(pf), .perf_stall(ps), .perf_flush(pfl)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .XLEN(32)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(pf2), .perf_stall(ps2), .perf_flush(pfl2)
`endif
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h200) return 32'h0062_8313;  // rs1=x5, rs2=x6
    return 32'h100 + (a >> 2);
  endfunction

  always @(posedge clk) begin
    bus.imem_rdata  <= memf(bus.imem_addr);
    bus2.imem_rdata <= memf(bus2.imem_addr);
  end

  typedef struct {
    logic        rst_n, stall, rv;
    logic [31:0] rpc;
    logic [31:0] addr, pc, instr;
    logic        vld;
    logic [4:0]  rs1, rs2;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int nvec = 0;
  int nmis = 0;

  function automatic vec_t mk(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                              input logic [31:0] addr, input logic [31:0] pc, input logic vld,
                              input logic [31:0] instr, input logic [4:0] rs1, input logic [4:0] rs2);
    vec_t v;
    v.rst_n = r; v.stall = s; v.rv = rv; v.rpc = rpc;
    v.addr = addr; v.pc = pc; v.vld = vld; v.instr = instr; v.rs1 = rs1; v.rs2 = rs2;
    return v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, want %h", name, act, exp);
      nmis++;
    end
  endtask

  initial begin
    vec_t e;
    rst_n = 1'b0; rst2_n = 1'b0;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus2.stall = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0;

    //            rst stl rv rpc           addr          pc            v instr          rs1 rs2
    vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,   32'h0,   0, 32'h13,       0, 0)); // 0 reset
    vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,   32'h0,   0, 32'h13,       0, 0)); // 1
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h4,   32'h0,   1, 32'h100,      0, 0)); // 2 free-run
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h8,   32'h4,   1, 32'h101,      0, 0)); // 3
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'hC,   32'h8,   1, 32'h102,      0, 0)); // 4
    vecs.push_back(mk(1, 1, 0, 32'h0,   32'hC,   32'h8,   1, 32'h102,      0, 0)); // 5 stall x3
    vecs.push_back(mk(1, 1, 0, 32'h0,   32'hC,   32'h8,   1, 32'h102,      0, 0)); // 6
    vecs.push_back(mk(1, 1, 0, 32'h0,   32'hC,   32'h8,   1, 32'h102,      0, 0)); // 7
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h10,  32'hC,   1, 32'h103,      0, 0)); // 8 release
    vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,   32'h0,   0, 32'h13,       0, 0)); // 9 reset
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h4,   32'h0,   1, 32'h100,      0, 0)); // 10
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h8,   32'h4,   1, 32'h101,      0, 0)); // 11
    vecs.push_back(mk(1, 0, 1, 32'h40,  32'h40,  32'h4,   0, 32'h13,       0, 0)); // 12 redirect
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h44,  32'h40,  1, 32'h110,      0, 0)); // 13
    vecs.push_back(mk(1, 1, 0, 32'h0,   32'h44,  32'h40,  1, 32'h110,      0, 0)); // 14 HOLD
    vecs.push_back(mk(1, 1, 1, 32'h43,  32'h40,  32'h40,  0, 32'h13,       0, 0)); // 15 redirect+stall
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h44,  32'h40,  1, 32'h110,      0, 0)); // 16
    vecs.push_back(mk(1, 0, 1, 32'h200, 32'h200, 32'h40,  0, 32'h13,       0, 0)); // 17
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h204, 32'h200, 1, 32'h0062_8313, 5, 6)); // 18
    vecs.push_back(mk(1, 1, 0, 32'h0,   32'h204, 32'h200, 1, 32'h0062_8313, 5, 6)); // 19
    vecs.push_back(mk(0, 1, 0, 32'h0,   32'h0,   32'h0,   0, 32'h13,       0, 0)); // 20 reset in stall
    vecs.push_back(mk(1, 1, 0, 32'h0,   32'h0,   32'h0,   0, 32'h13,       0, 0)); // 21 stall on bubble
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h4,   32'h0,   1, 32'h100,      0, 0)); // 22
    vecs.push_back(mk(1, 0, 0, 32'h0,   32'h8,   32'h4,   1, 32'h101,      0, 0)); // 23
    vecs.push_back(mk(1, 0, 1, 32'h40,  32'h40,  32'h4,   0, 32'h13,       0, 0)); // 24

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      bus.stall = vecs[i].stall;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc = vecs[i].rpc;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      nvec++;
      if (bus.imem_addr !== e.addr || bus.IFpc !== e.pc || bus.IFvalid !== e.vld ||
          bus.IFinstr !== e.instr || bus.IFrs1 !== e.rs1 || bus.IFrs2 !== e.rs2) begin
        $display("FAIL row%0d: got addr=%h pc=%h vld=%b instr=%h rs1=%0d rs2=%0d, want addr=%h pc=%h vld=%b instr=%h rs1=%0d rs2=%0d",
                 i, bus.imem_addr, bus.IFpc, bus.IFvalid, bus.IFinstr, bus.IFrs1, bus.IFrs2,
                 e.addr, e.pc, e.vld, e.instr, e.rs1, e.rs2);
        nmis++;
      end
`ifdef FETCH_PERF_CNT_EN
      if (i == 20) begin
        chk32("perf_fetched_rst", pf, 32'd0);
        chk32("perf_stall_rst", ps, 32'd0);
        chk32("perf_flush_rst", pfl, 32'd0);
      end
      if (i == 23) begin
        chk32("perf_fetched", pf, 32'd1);
        chk32("perf_stall", ps, 32'd1);
        chk32("perf_flush", pfl, 32'd0);
      end
      if (i == 24) begin
        chk32("perf_fetched_flush", pf, 32'd1);
        chk32("perf_flush_cnt", pfl, 32'd1);
      end
`endif
    end

    // PC wrap with a high reset vector
    @(negedge clk); rst2_n = 1'b0;
    @(posedge clk); #1;
    chk32("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFF8);
    chk32("wrap_vld0", {31'd0, bus2.IFvalid}, 32'd0);
    @(negedge clk); rst2_n = 1'b1;
    @(posedge clk); #1;
    chk32("wrap_addr1", bus2.imem_addr, 32'hFFFF_FFFC);
    chk32("wrap_pc1", bus2.IFpc, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    chk32("wrap_addr2", bus2.imem_addr, 32'h0000_0000);
    chk32("wrap_pc2", bus2.IFpc, 32'hFFFF_FFFC);
    chk32("wrap_instr2", bus2.IFinstr, memf(32'hFFFF_FFFC));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
